// File: rtl/pc_predict_reg_pkg.sv
// Shared constants, FSM state encoding and counter helper for the IF-stage PC generator.
package pc_predict_reg_pkg;

  localparam int ADDR_LEN = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_REDIR = 2'd2
  } pc_state_e;

  // 2-bit saturating direction counter levels
  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == CNT_ST) ? cnt : cnt + 2'd1;
    return (cnt == CNT_SNT) ? cnt : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/pc_bht.sv
// Direct-mapped branch table: combinational lookup port, synchronous training port.
// Addresses are word addresses (byte address >> 2).
module pc_bht
  import pc_predict_reg_pkg::*;
#(
  parameter int ADDR_W  = ADDR_LEN,
  parameter int ENTRIES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-3:0] lookup_word,
  output logic              hit,
  output logic              dir,
  output logic [ADDR_W-3:0] target_word,
  input  logic              upd_en,
  input  logic [ADDR_W-3:0] upd_word,
  input  logic              upd_taken,
  input  logic [ADDR_W-3:0] upd_target_word
);

  localparam int WORD_W = ADDR_W - 2;
  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int TAG_W  = WORD_W - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [WORD_W-1:0]  target_q [ENTRIES];
  logic [1:0]         cnt_q    [ENTRIES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             wr_hit;

  assign rd_idx = lookup_word[IDX_W-1:0];
  assign rd_tag = lookup_word[WORD_W-1:IDX_W];
  assign wr_idx = upd_word[IDX_W-1:0];
  assign wr_tag = upd_word[WORD_W-1:IDX_W];

  assign hit         = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign dir         = cnt_q[rd_idx][1];
  assign target_word = target_q[rd_idx];
  assign wr_hit      = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  // Writes land at the clock edge, so a same-cycle lookup sees the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
      end
    end else if (upd_en) begin
      if (wr_hit) begin
        cnt_q[wr_idx] <= cnt_next(cnt_q[wr_idx], upd_taken);
        if (upd_taken) target_q[wr_idx] <= upd_target_word;
      end else if (upd_taken) begin
        valid_q[wr_idx]  <= TRUE;
        tag_q[wr_idx]    <= wr_tag;
        target_q[wr_idx] <= upd_target_word;
        cnt_q[wr_idx]    <= CNT_WT;
      end
    end
  end

endmodule

// File: rtl/pc_predict_reg.sv
// IF-stage fetch PC generator: boot/run/redirect FSM, PC register and predicted next-PC mux.
// Handshake: pc_o is offered while pc_valid_o=1 and moves on only in a cycle where fetch_ready_i=1 and stall_i=0.
module pc_predict_reg
  import pc_predict_reg_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_LEN,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                BHT_ENTRIES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              fetch_ready_i,
  input  logic              stall_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_valid_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              upd_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i
);

  localparam int WORD_W = ADDR_W - 2;

  pc_state_e         state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] seq_word, tgt_word, pred_word;
  logic              bht_hit, bht_dir;
  logic              unused_low_bits;

  // PCs are kept as word addresses; byte-offset bits of inputs carry no meaning.
  assign unused_low_bits = ^{redirect_pc_i[1:0], upd_pc_i[1:0], upd_target_i[1:0]};

  pc_bht #(
    .ADDR_W (ADDR_W),
    .ENTRIES(BHT_ENTRIES)
  ) u_bht (
    .clk            (clk),
    .rst            (rst),
    .lookup_word    (pc_q),
    .hit            (bht_hit),
    .dir            (bht_dir),
    .target_word    (tgt_word),
    .upd_en         (rdy && upd_i),
    .upd_word       (upd_pc_i[ADDR_W-1:2]),
    .upd_taken      (upd_taken_i),
    .upd_target_word(upd_target_i[ADDR_W-1:2])
  );

  assign seq_word      = pc_q + 1'b1;
  assign pred_word     = bht_hit ? tgt_word : seq_word;
  assign pred_taken_o  = bht_hit && bht_dir;
  assign pred_target_o = {pred_word, 2'b00};
  assign pc_o          = {pc_q, 2'b00};
  assign pc_valid_o    = (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (!rdy) begin
      state_d = state_q;
    end else if (redirect_i) begin
      state_d = ST_REDIR;
      pc_d    = redirect_pc_i[ADDR_W-1:2];
    end else begin
      case (state_q)
        ST_BOOT:  state_d = ST_RUN;
        ST_REDIR: state_d = ST_RUN;
        ST_RUN: begin
          if (fetch_ready_i && !stall_i) pc_d = pred_taken_o ? pred_word : seq_word;
        end
        default:  state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC[ADDR_W-1:2];
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_pc_predict_reg.sv
// Bench for pc_predict_reg: directed vector table, multi-cycle reset sequence, and
// randomized traffic checked against an arithmetic reference model.
module tb_pc_predict_reg;

  localparam int          ADDR_W   = 32;
  localparam int          ENTRIES  = 64;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1, fetch_ready_i = 1'b1, stall_i = 1'b0, redirect_i = 1'b0;
  logic        upd_i = 1'b0, upd_taken_i = 1'b0;
  logic [31:0] redirect_pc_i = '0, upd_pc_i = '0, upd_target_i = '0;
  logic [31:0] pc_o, pred_target_o;
  logic        pc_valid_o, pred_taken_o;

  always #5 clk = ~clk;

  pc_predict_reg #(
    .ADDR_W     (ADDR_W),
    .RESET_PC   (RESET_PC),
    .BHT_ENTRIES(ENTRIES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .fetch_ready_i(fetch_ready_i),
    .stall_i      (stall_i),
    .pc_o         (pc_o),
    .pc_valid_o   (pc_valid_o),
    .pred_taken_o (pred_taken_o),
    .pred_target_o(pred_target_o),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .upd_i        (upd_i),
    .upd_pc_i     (upd_pc_i),
    .upd_taken_i  (upd_taken_i),
    .upd_target_i (upd_target_i)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  bit          m_valid;
  bit          m_vld [ENTRIES];
  logic [31:0] m_tag [ENTRIES];
  logic [31:0] m_tgt [ENTRIES];
  int          m_cnt [ENTRIES];

  function automatic int slot(input logic [31:0] a);
    return int'((a / 4) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / (4 * ENTRIES);
  endfunction

  function automatic void mdl_reset();
    m_pc    = RESET_PC;
    m_valid = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      m_vld[i] = 0;
      m_tag[i] = '0;
      m_tgt[i] = '0;
      m_cnt[i] = 1;
    end
  endfunction

  function automatic bit mdl_hit(input logic [31:0] a);
    return m_vld[slot(a)] && (m_tag[slot(a)] == tag_of(a));
  endfunction

  function automatic bit mdl_taken(input logic [31:0] a);
    return mdl_hit(a) && (m_cnt[slot(a)] >= 2);
  endfunction

  function automatic logic [31:0] mdl_target(input logic [31:0] a);
    logic [31:0] seq;
    seq = a + 32'd4;
    return mdl_hit(a) ? m_tgt[slot(a)] : seq;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  function automatic void mdl_step();
    int          i;
    logic [31:0] t;
    if (!rdy) return;
    if (redirect_i) begin
      m_pc    = redirect_pc_i & ~32'h3;
      m_valid = 0;
    end else if (!m_valid) begin
      m_valid = 1;
    end else if (fetch_ready_i && !stall_i) begin
      m_pc = mdl_taken(m_pc) ? mdl_target(m_pc) : m_pc + 32'd4;
    end
    if (upd_i) begin
      i = slot(upd_pc_i);
      t = tag_of(upd_pc_i);
      if (m_vld[i] && m_tag[i] == t) begin
        if (upd_taken_i) begin
          if (m_cnt[i] < 3) m_cnt[i]++;
          m_tgt[i] = upd_target_i & ~32'h3;
        end else if (m_cnt[i] > 0) begin
          m_cnt[i]--;
        end
      end else if (upd_taken_i) begin
        m_vld[i] = 1;
        m_tag[i] = t;
        m_tgt[i] = upd_target_i & ~32'h3;
        m_cnt[i] = 2;
      end
    end
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, ".pc"}, pc_o, m_pc);
    chk({tag, ".valid"}, pc_valid_o, m_valid);
    chk({tag, ".pred_taken"}, pred_taken_o, mdl_taken(m_pc));
    chk({tag, ".pred_target"}, pred_target_o, mdl_target(m_pc));
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          rdy, fr, st, rd;
    logic [31:0] rpc;
    bit          up;
    logic [31:0] upc;
    bit          utk;
    logic [31:0] utg;
    logic [31:0] epc;
    bit          ev, ept;
    logic [31:0] etg;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input bit rdy_v, fr, st, rd, input logic [31:0] rpc,
                              input bit up, input logic [31:0] upc, input bit utk,
                              input logic [31:0] utg, input logic [31:0] epc,
                              input bit ev, ept, input logic [31:0] etg);
    vec_t v;
    v.rdy = rdy_v; v.fr = fr; v.st = st; v.rd = rd; v.rpc = rpc;
    v.up = up; v.upc = upc; v.utk = utk; v.utg = utg;
    v.epc = epc; v.ev = ev; v.ept = ept; v.etg = etg;
    return v;
  endfunction

  task automatic drive_idle();
    rdy = 1; fetch_ready_i = 1; stall_i = 0; redirect_i = 0; redirect_pc_i = '0;
    upd_i = 0; upd_pc_i = '0; upd_taken_i = 0; upd_target_i = '0;
  endtask

  task automatic drive(input vec_t v);
    rdy = v.rdy; fetch_ready_i = v.fr; stall_i = v.st; redirect_i = v.rd;
    redirect_pc_i = v.rpc; upd_i = v.up; upd_pc_i = v.upc;
    upd_taken_i = v.utk; upd_target_i = v.utg;
  endtask

  task automatic model_cycle(input string tag);
    @(negedge clk);
    chk_model(tag);
    mdl_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   rdy fr st rd  rpc            up upc     tk utg        | pc            v  pt tgt
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,     32'h0,        0, 0, 32'h4));   // boot bubble
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,     32'h0,        1, 0, 32'h4));
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,     32'h4,        1, 0, 32'h8));
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,     32'h8,        1, 0, 32'hC));
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,     32'hC,        1, 0, 32'h10));
    vq.push_back(mk(1, 1, 1, 0, 32'h0,        0, 32'h0,  0, 32'h0,     32'h10,       1, 0, 32'h14));  // stall
    vq.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,     32'h10,       1, 0, 32'h14));  // fetch not ready
    vq.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h14, 1, 32'h80,    32'h10,       1, 0, 32'h14));  // rdy=0 freezes
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,     32'h10,       1, 0, 32'h14));
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        1, 32'h20, 1, 32'h100,   32'h14,       1, 0, 32'h18));  // allocate 0x20
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,     32'h18,       1, 0, 32'h1C));
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,     32'h1C,       1, 0, 32'h20));
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,     32'h20,       1, 1, 32'h100)); // predicted taken
    vq.push_back(mk(1, 1, 0, 1, 32'h23,       0, 32'h0,  0, 32'h0,     32'h100,      1, 0, 32'h104));
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        1, 32'h20, 0, 32'h0,     32'h20,       0, 1, 32'h100)); // lookup sees old cnt
    vq.push_back(mk(1, 1, 1, 0, 32'h0,        1, 32'h20, 0, 32'h0,     32'h20,       1, 0, 32'h100));
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        1, 32'h20, 0, 32'h0,     32'h20,       1, 0, 32'h100)); // floor at 00
    vq.push_back(mk(1, 1, 0, 1, 32'h20,       0, 32'h0,  0, 32'h0,     32'h24,       1, 0, 32'h28));
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,     32'h20,       0, 0, 32'h100));
    vq.push_back(mk(1, 1, 0, 1, 32'h40,       0, 32'h0,  0, 32'h0,     32'h20,       1, 0, 32'h100));
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,     32'h40,       0, 0, 32'h44));
    vq.push_back(mk(1, 1, 1, 1, 32'h203,      0, 32'h0,  0, 32'h0,     32'h40,       1, 0, 32'h44));  // redirect beats stall
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,     32'h200,      0, 0, 32'h204));
    vq.push_back(mk(1, 1, 0, 1, 32'h300,      0, 32'h0,  0, 32'h0,     32'h200,      1, 0, 32'h204));
    vq.push_back(mk(1, 1, 0, 1, 32'h400,      0, 32'h0,  0, 32'h0,     32'h300,      0, 0, 32'h304)); // redirect in bubble
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,     32'h400,      0, 0, 32'h404));
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,     32'h400,      1, 0, 32'h404));
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        1, 32'h20, 1, 32'h100,   32'h404,      1, 0, 32'h408));
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        1, 32'h20, 1, 32'h100,   32'h408,      1, 0, 32'h40C));
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        1, 32'h20, 1, 32'h100,   32'h40C,      1, 0, 32'h410));
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        1, 32'h20, 1, 32'h100,   32'h410,      1, 0, 32'h414)); // ceiling at 11
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        1, 32'h20, 0, 32'h0,     32'h414,      1, 0, 32'h418));
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        1, 32'h20, 0, 32'h0,     32'h418,      1, 0, 32'h41C));
    vq.push_back(mk(1, 1, 0, 1, 32'h20,       0, 32'h0,  0, 32'h0,     32'h41C,      1, 0, 32'h420));
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,     32'h20,       0, 0, 32'h100));
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,     32'h20,       1, 0, 32'h100)); // falls through
    vq.push_back(mk(1, 1, 0, 1, 32'h120,      1, 32'h20, 1, 32'h100,   32'h24,       1, 0, 32'h28));
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        1, 32'h120, 0, 32'h0,    32'h120,      0, 0, 32'h124)); // alias miss
    vq.push_back(mk(1, 1, 0, 1, 32'h20,       0, 32'h0,  0, 32'h0,     32'h120,      1, 0, 32'h124));
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,     32'h20,       0, 1, 32'h100));
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,     32'h20,       1, 1, 32'h100));
    vq.push_back(mk(1, 1, 0, 1, 32'hFFFFFFFC, 0, 32'h0,  0, 32'h0,     32'h100,      1, 0, 32'h104));
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,     32'hFFFFFFFC, 0, 0, 32'h0));
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,     32'hFFFFFFFC, 1, 0, 32'h0));   // wraps
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,     32'h0,        1, 0, 32'h4));

    // ---- reset state ----
    drive_idle();
    rst = 1;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.pc", pc_o, RESET_PC);
    chk("reset.valid", pc_valid_o, 1'b0);
    chk("reset.pred_taken", pred_taken_o, 1'b0);
    rst = 0;

    // ---- directed table ----
    foreach (vq[i]) begin
      drive(vq[i]);
      @(negedge clk);
      chk($sformatf("vec%0d.pc", i), pc_o, vq[i].epc);
      chk($sformatf("vec%0d.valid", i), pc_valid_o, vq[i].ev);
      chk($sformatf("vec%0d.pred_taken", i), pred_taken_o, vq[i].ept);
      chk($sformatf("vec%0d.pred_target", i), pred_target_o, vq[i].etg);
      mdl_step();
      @(posedge clk);
      #1;
    end

    // ---- asynchronous reset in the middle of operation ----
    drive_idle();
    redirect_i = 1; redirect_pc_i = 32'h20;
    model_cycle("mid.redir");
    redirect_i = 0;
    @(negedge clk);
    chk("mid.trained_taken", pred_taken_o, 1'b1);
    #2 rst = 1;
    #1;
    chk("mid.async_pc", pc_o, RESET_PC);
    chk("mid.async_valid", pc_valid_o, 1'b0);
    chk("mid.async_taken", pred_taken_o, 1'b0);
    mdl_reset();
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("mid.boot_valid", pc_valid_o, 1'b0);
    mdl_step();
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid.first_pc", pc_o, RESET_PC);
    chk("mid.first_valid", pc_valid_o, 1'b1);
    mdl_step();
    @(posedge clk);
    #1;
    redirect_i = 1; redirect_pc_i = 32'h20;
    model_cycle("mid.revisit");
    redirect_i = 0;
    @(negedge clk);
    chk("mid.cleared_taken", pred_taken_o, 1'b0);
    chk("mid.cleared_target", pred_target_o, 32'h24);
    mdl_step();
    @(posedge clk);
    #1;

    // ---- randomized traffic vs. model ----
    for (int c = 0; c < 2000; c++) begin
      rdy           = ($urandom_range(0, 9) != 0);
      fetch_ready_i = ($urandom_range(0, 4) != 0);
      stall_i       = ($urandom_range(0, 4) == 0);
      redirect_i    = ($urandom_range(0, 11) == 0);
      redirect_pc_i = ($urandom_range(0, 19) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                                   : 32'($urandom_range(0, 32'h3FF));
      upd_i         = ($urandom_range(0, 9) < 4);
      upd_pc_i      = 32'($urandom_range(0, 32'h3FF));
      upd_taken_i   = ($urandom_range(0, 2) != 0);
      upd_target_i  = 32'($urandom_range(0, 32'h3FF));
      model_cycle($sformatf("rand%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by %0t, expected finish", $time);
    $fatal(1);
  end

endmodule

// File: doc/pc_predict_reg.md
Name: pc_predict_reg

Overview:
- Parametrised program-counter generator for the IF stage of the RISC-V core.
- Holds the fetch PC and issues it to instruction fetch over a valid/ready handshake.
- Predicts next PC from a direct-mapped branch table (valid, tag, target, 2-bit saturating counter) trained by EX.
- Accepts redirect (mispredict/jump) from EX with a one-cycle bubble.

Parameters:
- ADDR_W, 32, PC/address width in bits.
- RESET_PC, 32'h0, PC value loaded on reset.
- BHT_ENTRIES, 64, table entries; power of 2, >= 2. IDX_W = log2(BHT_ENTRIES), TAG_W = ADDR_W-IDX_W-2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global chip ready; 0 freezes all state
- fetch_ready_i  in  1  fetch accepts pc_o this cycle
- stall_i  in  1  pipeline stall; holds PC
- pc_o  out  ADDR_W  current fetch PC, bits [1:0] always 0
- pc_valid_o  out  1  pc_o is valid for fetch
- pred_taken_o  out  1  prediction for pc_o (combinational from table)
- pred_target_o  out  ADDR_W  predicted target for pc_o (combinational)
- redirect_i  in  1  EX flush/redirect request
- redirect_pc_i  in  ADDR_W  redirect address; bits [1:0] ignored
- upd_i  in  1  table training strobe from EX
- upd_pc_i  in  ADDR_W  PC of resolved branch/jump
- upd_taken_i  in  1  resolved direction
- upd_target_i  in  ADDR_W  resolved target

Behaviour:
- Clock clk; reset rst is asynchronous and active-high. Reset: pc_o=RESET_PC, pc_valid_o=0, state=BOOT, all entries valid=0, counter=2'b01, tag/target=0. pred_taken_o=0 while reset is asserted.
- Lookup: idx=pc_o[IDX_W+1:2], tag=pc_o[ADDR_W-1:IDX_W+2]. hit = valid && tag match. pred_taken_o = hit && counter[1]; pred_target_o = hit ? target : pc_o+4.
- Priority per cycle: rst > !rdy (hold everything, incl. table) > redirect_i > advance/hold.
- States:
  - BOOT: pc_valid_o=0. Next rdy cycle -> RUN, pc_valid_o<=1.
  - RUN: pc_valid_o=1.
    - Advance when fetch_ready_i && !stall_i: pc_o <= pred_taken_o ? pred_target_o : pc_o+4.
    - Otherwise hold pc_o.
  - REDIR: pc_valid_o=0 for exactly one cycle, then RUN.
- redirect_i (rdy=1), any state: pc_o <= {redirect_pc_i[ADDR_W-1:2],2'b00}, pc_valid_o<=0, state<=REDIR. This overrides stall_i and fetch_ready_i. Redirect while in REDIR loads the new PC and stays in REDIR one more cycle.
- Latency: redirect at cycle N -> pc_valid_o=1 with new PC at N+2.
- Arithmetic: pc_o+4 is modulo 2^ADDR_W ({ADDR_W{1'b1}}-3 wraps to 0). Targets are stored with [1:0] forced to 0.
- Training (rdy && upd_i), independent of redirect/stall:
  - Hit: counter saturating +1 if taken (max 11), -1 if not taken (min 00); target<=upd_target_i if taken.
  - Miss and taken: allocate valid=1, tag, target, counter=2'b10.
  - Miss and not taken: no change.
- Same-cycle update and lookup of one index: lookup sees the old contents; the write is visible next cycle.
- Reset asserted mid-operation clears all state immediately, including table and FSM. The first valid PC after release is RESET_PC, in the second rdy cycle after release.

Decomposition:
- Shared config package: `AddrLen, `ZERO_WORD, `True/`False, state encodings (BOOT/RUN/REDIR, 2-bit), counter init constants (CNT_WNT=01, CNT_WT=10).
- One sub-module: pc_bht. Holds the table with a combinational read port (lookup) and a synchronous write port (training), plus async reset of valid/counters.
- pc_predict_reg keeps the FSM, PC register, and next-PC mux.

Test Plan:
- Reset/boot: rst=1 then release, rdy=1, fetch_ready_i=1 -> pc_valid_o 0 for the BOOT cycle, then pc_o=0,4,8,... one per cycle; pred_taken_o=0.
- Hold: stall_i=1 or fetch_ready_i=0 at pc_o=0x10 for 3 cycles -> pc_o stays 0x10. rdy=0 with upd_i=1 -> no PC or table change.
- Redirect: redirect_i with redirect_pc_i=0x203 at pc_o=0x40 while stall_i=1 -> next cycle pc_o=0x200, pc_valid_o=0. Cycle after: pc_valid_o=1. Back-to-back redirects to 0x300 then 0x400 -> two bubbles, resumes at 0x400.
- Training/prediction: upd pc=0x20 taken target=0x100 -> entry allocated with counter 10. Later pc_o=0x20 -> pred_taken_o=1, next pc_o=0x100. Two not-taken updates -> counter 00, next visit goes to 0x24.
- Saturation/alias: three taken updates -> counter stays 11. Lookup of 0x20+4*BHT_ENTRIES (same idx, different tag) -> miss, pred_taken_o=0. Not-taken update on a miss -> entry unchanged.
- Wrap and mid-op reset: pc_o=0xFFFFFFFC advancing -> 0x0. Async rst pulse mid-RUN -> pc_o=RESET_PC and pc_valid_o=0 immediately, and a previously trained entry misses afterwards.
